// File: rtl/fetch_unit.sv
// Parametrised PC / instruction-fetch stage with a one-outstanding req/gnt/rsp memory port.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned redirects trap to TRAP_VEC instead of being aligned.
module fetch_unit #(
    parameter int unsigned     PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(32'h100)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch,
    input  logic            zero,
    input  logic            jump,
    input  logic            jalr,
    input  logic [PC_W-1:0] exPc,
    input  logic [31:0]     imm,
    input  logic [31:0]     rs1,
    output logic            imemReq,
    output logic [PC_W-1:0] imemAddr,
    input  logic            imemGnt,
    input  logic            imemRspValid,
    input  logic [31:0]     imemRspData,
    output logic            instrValid,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pcPlus4,
    output logic            trap
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic            kill_q, kill_d;
    logic            instr_valid_q;
    logic [31:0]     instr_q;
    logic [PC_W-1:0] pc_q;
    logic            req;
    logic            load;

    // Redirect target: sums formed at 32 bits, then truncated to PC_W (silent wrap).
    logic            redir;
    logic [31:0]     sum_jalr;
    logic [31:0]     sum_br;
    logic [31:0]     target_full;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] redir_pc;
    logic            redir_trap;

    assign redir       = jalr | jump | (branch & zero);
    assign sum_jalr    = rs1 + imm;
    assign sum_br      = 32'(exPc) + imm;
    assign target_full = jalr ? (sum_jalr & ~32'd1) : sum_br;
    assign target      = target_full[PC_W-1:0];

    generate
        if (PC_W < 32) begin : g_trunc
            logic unused_hi;
            assign unused_hi = ^target_full[31:PC_W];
        end
    endgenerate

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign;
    logic trap_q;

    assign misalign   = |target[1:0];
    assign redir_pc   = misalign ? TRAP_VEC : target;
    assign redir_trap = redir & misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= redir_trap;
        end
    end

    assign trap = trap_q;
`else
    logic unused_lo;

    assign unused_lo  = ^target[1:0];
    assign redir_pc   = {target[PC_W-1:2], 2'b00};
    assign redir_trap = 1'b0;
    assign trap       = redir_trap;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_q;
        req        = 1'b0;
        load       = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                req = !instr_valid_q || !stall;
                if (req && imemGnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imemRspValid) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                    if (!kill_q && !redir) begin
                        load       = 1'b1;
                        fetch_pc_d = fetch_pc_q + PC_W'(4);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A response still owed by memory must be discarded once the PC moves.
        if (redir) begin
            fetch_pc_d = redir_pc;
            if ((state_q == S_WAIT && !imemRspValid) || (state_q == S_REQ && req && imemGnt)) begin
                kill_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_VEC;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            kill_q     <= kill_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            pc_q          <= '0;
        end else if (redir) begin
            instr_valid_q <= 1'b0;
        end else if (load) begin
            instr_valid_q <= 1'b1;
            instr_q       <= imemRspData;
            pc_q          <= fetch_pc_q;
        end else if (!stall) begin
            instr_valid_q <= 1'b0;
        end
    end

    assign imemReq    = req;
    assign imemAddr   = fetch_pc_q;
    assign instrValid = instr_valid_q;
    assign instr      = instr_q;
    assign pc         = pc_q;
    assign pcPlus4    = pc_q + PC_W'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch addresses and instr/pc pairs are queued by the
// stimulus and consumed by negedge monitors on grant and on decode acceptance.
module tb_fetch_unit;

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic        EXP_TRAP = 1'b1;
    localparam logic [31:0] EXP_B    = 32'h0000_0100;
`else
    localparam logic        EXP_TRAP = 1'b0;
    localparam logic [31:0] EXP_B    = 32'h0000_0020;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, branch = 1'b0, zero = 1'b0, jump = 1'b0, jalr = 1'b0;
    logic [31:0] exPc = '0, imm = '0, rs1 = '0;
    logic        imemGnt = 1'b0, imemRspValid = 1'b0;
    logic [31:0] imemRspData = '0;
    logic        imemReq, instrValid, trap;
    logic [31:0] imemAddr, instr, pc, pcPlus4;

    logic        s_jump = 1'b0;
    logic [15:0] s_exPc = '0;
    logic [31:0] s_imm = '0;
    logic        s_req, s_ivalid, s_trap;
    logic [15:0] s_addr, s_pc, s_pcp4;
    logic [31:0] s_instr;

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .zero(zero),
        .jump(jump), .jalr(jalr), .exPc(exPc), .imm(imm), .rs1(rs1),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
        .imemRspValid(imemRspValid), .imemRspData(imemRspData),
        .instrValid(instrValid), .instr(instr), .pc(pc), .pcPlus4(pcPlus4), .trap(trap)
    );

    fetch_unit #(.PC_W(16)) u_small (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .branch(1'b0), .zero(1'b0),
        .jump(s_jump), .jalr(1'b0), .exPc(s_exPc), .imm(s_imm), .rs1(32'h0),
        .imemReq(s_req), .imemAddr(s_addr), .imemGnt(1'b0),
        .imemRspValid(1'b0), .imemRspData(32'h0),
        .instrValid(s_ivalid), .instr(s_instr), .pc(s_pc), .pcPlus4(s_pcp4), .trap(s_trap)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] addr_q[$];
    logic [31:0] instr_q[$];
    logic [31:0] pc_q[$];

    int          lat = 1;
    int          cnt = 0;
    bit          pend = 1'b0;
    logic [31:0] paddr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: answers a grant after 'lat' cycles with 0xC0DE_xxxx, xxxx = low address bits.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            imemRspValid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imemRspValid = 1'b1;
                    imemRspData  = 32'hC0DE_0000 | {16'h0, paddr[15:0]};
                    pend         = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && imemReq && imemGnt) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = imemAddr;
            if (addr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_req: got addr %h expected no request", imemAddr);
            end else begin
                check("imem_addr", imemAddr, addr_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] ep;
        if (rst_n && instrValid && !stall) begin
            if (instr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_instr: got instr %h pc %h expected none", instr, pc);
            end else begin
                ep = pc_q.pop_front();
                check("instr", instr, instr_q.pop_front());
                check("pc", pc, ep);
                check("pc_plus4", pcPlus4, ep + 32'd4);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        addr_q.push_back(a);
        instr_q.push_back(32'hC0DE_0000 | {16'h0, a[15:0]});
        pc_q.push_back(a);
    endtask

    task automatic run_until_granted();
        for (int i = 0; i < 100; i++) begin
            step();
            if (addr_q.size() == 0) break;
        end
        imemGnt = 1'b0;
        if (addr_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: got %0d pending expected 0", addr_q.size());
            addr_q.delete();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (instr_q.size() == 0) break;
            step();
        end
        if (instr_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", instr_q.size());
            instr_q.delete();
            pc_q.delete();
        end
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(instrValid), 32'd0);
        check("rst_req", 32'(imemReq), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_trap", 32'(trap), 32'd0);

        // Sequential fetch 0,4,8 with 1-cycle grant/response.
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        expect_fetch(32'h8);
        imemGnt = 1'b1;
        step();
        rst_n = 1'b1;
        run_until_granted();
        drain();

        // 16-bit PC wrap: 0xFFFC + 8 -> 0x0004.
        s_jump = 1'b1; s_exPc = 16'hFFFC; s_imm = 32'h8;
        step();
        s_jump = 1'b0; s_exPc = '0; s_imm = '0;
        @(negedge clk);
        check("wrap16_addr", 32'(s_addr), 32'h0004);
        check("wrap16_trap", 32'(s_trap), 32'd0);
        step();

        // Stall with a valid instruction: output held, no request.
        stall = 1'b1;
        expect_fetch(32'hC);
        imemGnt = 1'b1;
        run_until_granted();
        for (int i = 0; i < 20; i++) begin
            if (instrValid) break;
            step();
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(instrValid), 32'd1);
            check("stall_instr", instr, 32'hC0DE_000C);
            check("stall_pc", pc, 32'hC);
            check("stall_noreq", 32'(imemReq), 32'd0);
        end
        step();
        stall = 1'b0;
        drain();

        // Jump during WAIT: pending response for 0x10 dropped, refetch at 0x60.
        lat = 3;
        addr_q.push_back(32'h10);
        imemGnt = 1'b1;
        run_until_granted();
        jump = 1'b1; exPc = 32'h20; imm = 32'h40;
        step();
        jump = 1'b0; exPc = '0; imm = '0;
        lat = 1;
        expect_fetch(32'h60);
        imemGnt = 1'b1;
        run_until_granted();
        drain();

        // jalr beats branch&zero; target 0x102 is aligned down or trapped to 0x100.
        jalr = 1'b1; branch = 1'b1; zero = 1'b1; rs1 = 32'h103; imm = 32'h0; exPc = 32'h40;
        step();
        jalr = 1'b0; branch = 1'b0; zero = 1'b0; rs1 = '0; exPc = '0;
        @(negedge clk);
        check("jalr_trap", 32'(trap), 32'(EXP_TRAP));
        check("jalr_addr", imemAddr, 32'h100);
        step();
        @(negedge clk);
        check("jalr_trap_end", 32'(trap), 32'd0);
        expect_fetch(32'h100);
        imemGnt = 1'b1;
        run_until_granted();
        drain();

        // Branch to misaligned 0x22.
        branch = 1'b1; zero = 1'b1; exPc = 32'h20; imm = 32'h2;
        step();
        branch = 1'b0; zero = 1'b0; exPc = '0; imm = '0;
        @(negedge clk);
        check("br_trap", 32'(trap), 32'(EXP_TRAP));
        check("br_addr", imemAddr, EXP_B);
        step();
        expect_fetch(EXP_B);
        imemGnt = 1'b1;
        run_until_granted();
        drain();

        // Redirect in REQ on the granting cycle: that response is dropped.
        addr_q.push_back(EXP_B + 32'd4);
        expect_fetch(32'h200);
        imemGnt = 1'b1;
        jump = 1'b1; exPc = 32'h0; imm = 32'h200;
        step();
        jump = 1'b0; imm = '0;
        run_until_granted();
        drain();

        // Reset mid-transaction: late response ignored, fetch restarts at RESET_VEC.
        lat = 2;
        addr_q.push_back(32'h204);
        imemGnt = 1'b1;
        run_until_granted();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(instrValid), 32'd0);
        check("mid_rst_req", 32'(imemReq), 32'd0);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_instr", instr, 32'h0);
        check("mid_rst_addr", imemAddr, 32'h0);
        repeat (3) step();
        lat = 1;
        expect_fetch(32'h0);
        imemGnt = 1'b1;
        rst_n = 1'b1;
        run_until_granted();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
